// File: rtl/uart_pkg.sv
// Shared UART definitions: frame state encoding, oversampling constants and
// the majority-vote helper used by the receiver's mid-bit sampler.
package uart_pkg;

    // Ticks per bit; the receiver's tick bookkeeping assumes exactly 16.
    localparam int UART_OVERSAMPLE = 16;
    // Payload bits per frame, sent LSB first.
    localparam int UART_DATA_BITS  = 8;

    // Oversample tick indices inside one bit period.
    localparam logic [3:0] VOTE_FIRST = 4'd7;
    localparam logic [3:0] VOTE_MID   = 4'd8;
    localparam logic [3:0] VOTE_LAST  = 4'd9;
    localparam logic [3:0] BIT_LAST   = 4'd15;

    // Frame states shared by transmitter and receiver.
    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        START = 3'd1,
        DATA  = 3'd2,
        STOP  = 3'd3,
        BREAK = 3'd4
    } uart_state_e;

    // 2-of-3 majority of three line samples.
    function automatic logic majority3(input logic a, input logic b, input logic c);
        return (a & b) | (a & c) | (b & c);
    endfunction

endpackage

// File: rtl/uart_rx_if.sv
// Byte-side and line-side signals of the UART receiver. The receiver is the
// master of the byte outputs; the pin/consumer side is the slave.
interface uart_rx_if #(
    parameter int DATA_BITS = 8
);
    logic                 rx_in;
    logic [DATA_BITS-1:0] data_out;
    logic                 data_valid;
    logic                 frame_err;
    logic                 busy;

    modport master (
        input  rx_in,
        output data_out,
        output data_valid,
        output frame_err,
        output busy
    );

    modport slave (
        output rx_in,
        input  data_out,
        input  data_valid,
        input  frame_err,
        input  busy
    );
endinterface

// File: rtl/rx_sample_tick.sv
// Oversample tick generator: one-clock tick every CLK_DIV clocks. A
// synchronous clear restarts the count so ticks line up with a start edge.
module rx_sample_tick #(
    parameter int CLK_DIV = 434
) (
    input  logic clk,
    input  logic rst_n,
    input  logic clr,
    output logic tick
);

    localparam int CW = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;

    logic [CW-1:0] cnt_r;
    logic          tick_r;
    logic          wrap_s;

    assign wrap_s = (cnt_r == CW'(CLK_DIV - 1));
    assign tick   = tick_r;

    // Divider counter and registered tick pulse at each wrap.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_r  <= {CW{1'b0}};
            tick_r <= 1'b0;
        end else if (clr) begin
            cnt_r  <= {CW{1'b0}};
            tick_r <= 1'b0;
        end else if (wrap_s) begin
            cnt_r  <= {CW{1'b0}};
            tick_r <= 1'b1;
        end else begin
            cnt_r  <= cnt_r + CW'(1);
            tick_r <= 1'b0;
        end
    end

endmodule

// File: rtl/uart_rx.sv
// 8N1 UART receiver. The line is synchronised, oversampled x16 and each bit
// is decided by a 2-of-3 vote at ticks 7/8/9. Good bytes appear on data_out
// with a one-clock data_valid; a low stop bit gives a one-clock frame_err.
module uart_rx
    import uart_pkg::*;
#(
    parameter int CLK_DIV    = 434,
    parameter int OVERSAMPLE = UART_OVERSAMPLE,
    parameter int DATA_BITS  = UART_DATA_BITS
) (
    input  logic      clk,
    input  logic      rst_n,
    uart_rx_if.master rx_bus
);

    localparam int BCW = (DATA_BITS > 1) ? $clog2(DATA_BITS) : 1;

    // Line synchroniser and start-edge qualification.
    logic           sync1_r;
    logic           sync2_r;
    logic           rx_s;
    logic [1:0]     fill_cnt_r;
    logic           armed_r;
    logic           start_det_s;

    // Bit timing.
    logic           tick_s;
    logic [3:0]     samp_cnt_r;
    logic [BCW-1:0] bit_cnt_r;
    logic           at_vote_s;
    logic           at_end_s;

    // Voting and payload.
    logic           vote_a_r;
    logic           vote_b_r;
    logic           vote_s;
    logic [DATA_BITS-1:0] shift_r;

    // FSM and output staging.
    uart_state_e    state_r;
    uart_state_e    state_nxt_s;
    logic           shift_en_s;
    logic           load_s;
    logic           valid_nxt_s;
    logic           err_nxt_s;

    logic [DATA_BITS-1:0] data_out_r;
    logic           data_valid_r;
    logic           frame_err_r;
    logic           busy_r;

    assign rx_s        = sync2_r;
    // A start needs the line to have been genuinely high on the previous
    // clock, so a line already low when reset lifts is not taken as a start.
    assign start_det_s = (state_r == IDLE) && armed_r && !rx_s;
    assign at_vote_s   = tick_s && (samp_cnt_r == VOTE_LAST);
    assign at_end_s    = tick_s && (samp_cnt_r == BIT_LAST);
    assign vote_s      = majority3(vote_a_r, vote_b_r, rx_s);

    assign rx_bus.data_out   = data_out_r;
    assign rx_bus.data_valid = data_valid_r;
    assign rx_bus.frame_err  = frame_err_r;
    assign rx_bus.busy       = busy_r;

    rx_sample_tick #(
        .CLK_DIV (CLK_DIV)
    ) u_tick (
        .clk   (clk),
        .rst_n (rst_n),
        .clr   (start_det_s),
        .tick  (tick_s)
    );

    // Two-flop synchroniser, reset to the idle (high) line level.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync1_r <= 1'b1;
            sync2_r <= 1'b1;
        end else begin
            sync1_r <= rx_bus.rx_in;
            sync2_r <= sync1_r;
        end
    end

    // Arms start detection once the synchroniser holds real line samples
    // and the line was seen high.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            fill_cnt_r <= 2'd0;
            armed_r    <= 1'b0;
        end else begin
            if (fill_cnt_r != 2'd3) begin
                fill_cnt_r <= fill_cnt_r + 2'd1;
            end else begin
                fill_cnt_r <= fill_cnt_r;
            end
            armed_r <= fill_cnt_r[1] && rx_s;
        end
    end

    // Tick position within the bit and payload bit index.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            samp_cnt_r <= 4'd0;
            bit_cnt_r  <= {BCW{1'b0}};
        end else if (start_det_s) begin
            samp_cnt_r <= 4'd0;
            bit_cnt_r  <= {BCW{1'b0}};
        end else begin
            if (tick_s) begin
                if (samp_cnt_r == BIT_LAST) begin
                    samp_cnt_r <= 4'd0;
                end else begin
                    samp_cnt_r <= samp_cnt_r + 4'd1;
                end
            end else begin
                samp_cnt_r <= samp_cnt_r;
            end
            if ((state_r == DATA) && at_end_s) begin
                bit_cnt_r <= bit_cnt_r + BCW'(1);
            end else begin
                bit_cnt_r <= bit_cnt_r;
            end
        end
    end

    // Captures the first two vote samples; the third is taken live.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            vote_a_r <= 1'b1;
            vote_b_r <= 1'b1;
        end else if (tick_s && (samp_cnt_r == VOTE_FIRST)) begin
            vote_a_r <= rx_s;
        end else if (tick_s && (samp_cnt_r == VOTE_MID)) begin
            vote_b_r <= rx_s;
        end else begin
            vote_a_r <= vote_a_r;
            vote_b_r <= vote_b_r;
        end
    end

    // LSB-first payload shift register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            shift_r <= {DATA_BITS{1'b0}};
        end else if (shift_en_s) begin
            shift_r <= {vote_s, shift_r[DATA_BITS-1:1]};
        end else begin
            shift_r <= shift_r;
        end
    end

    // FSM state register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r <= IDLE;
        end else begin
            state_r <= state_nxt_s;
        end
    end

    // Next-state and output strobes for the frame FSM.
    always_comb begin
        state_nxt_s = state_r;
        shift_en_s  = 1'b0;
        load_s      = 1'b0;
        valid_nxt_s = 1'b0;
        err_nxt_s   = 1'b0;
        case (state_r)
            IDLE: begin
                if (start_det_s) begin
                    state_nxt_s = START;
                end else begin
                    state_nxt_s = IDLE;
                end
            end
            START: begin
                if (at_vote_s && vote_s) begin
                    state_nxt_s = IDLE;
                end else if (at_end_s) begin
                    state_nxt_s = DATA;
                end else begin
                    state_nxt_s = START;
                end
            end
            DATA: begin
                if (at_vote_s) begin
                    shift_en_s = 1'b1;
                end else begin
                    shift_en_s = 1'b0;
                end
                if (at_end_s && (bit_cnt_r == BCW'(DATA_BITS - 1))) begin
                    state_nxt_s = STOP;
                end else begin
                    state_nxt_s = DATA;
                end
            end
            STOP: begin
                // Leave at the vote point so a start edge in the second half
                // of the stop bit is still caught.
                if (at_vote_s) begin
                    if (vote_s) begin
                        load_s      = 1'b1;
                        valid_nxt_s = 1'b1;
                        state_nxt_s = IDLE;
                    end else begin
                        err_nxt_s   = 1'b1;
                        state_nxt_s = BREAK;
                    end
                end else begin
                    state_nxt_s = STOP;
                end
            end
            BREAK: begin
                if (rx_s) begin
                    state_nxt_s = IDLE;
                end else begin
                    state_nxt_s = BREAK;
                end
            end
            default: begin
                state_nxt_s = IDLE;
            end
        endcase
    end

    // Registered byte-side outputs.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            data_out_r   <= {DATA_BITS{1'b0}};
            data_valid_r <= 1'b0;
            frame_err_r  <= 1'b0;
            busy_r       <= 1'b0;
        end else begin
            if (load_s) begin
                data_out_r <= shift_r;
            end else begin
                data_out_r <= data_out_r;
            end
            data_valid_r <= valid_nxt_s;
            frame_err_r  <= err_nxt_s;
            busy_r       <= (state_nxt_s != IDLE);
        end
    end

endmodule
